// File: rtl/memory_pkg.sv
// Shared types and constants for the memory_sync_dp simple-dual-port SRAM.
package memory_pkg;

  typedef enum logic {
    MEM_INIT = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

  localparam bit MEM_READ_FIRST  = 1'b0;
  localparam bit MEM_WRITE_FIRST = 1'b1;

endpackage

// File: rtl/memory_rd_pipe.sv
// L-stage read-result pipeline: valid bits are async-reset, data stages hold
// their last value so the final stage presents the most recent result.
module memory_rd_pipe #(
  parameter int N = 32,
  parameter int L = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_vld,
  input  logic [N-1:0] in_data,
  output logic         out_vld,
  output logic [N-1:0] out_data
);

  logic [L-1:0] vld_q, vld_d;
  logic [N-1:0] dat_q [L];
  logic [N-1:0] dat_d [L];
  logic [N-1:0] stage_in [L];

  always_comb begin
    vld_d[0]    = in_vld;
    stage_in[0] = in_data;
    for (int i = 1; i < L; i++) begin
      vld_d[i]    = vld_q[i-1];
      stage_in[i] = dat_q[i-1];
    end
    for (int i = 0; i < L; i++) begin
      dat_d[i] = vld_d[i] ? stage_in[i] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < L; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_vld  = vld_q[L-1];
  assign out_data = dat_q[L-1];

endmodule

// File: rtl/memory_sync_dp.sv
// Simple-dual-port SRAM with byte strobes, registered read of latency L and
// selectable collision mode. Define MEMORY_INIT_EN to build the post-reset fill sweep.
//
// state    | meaning
// MEM_INIT | sweeping every word to {N{RV}}; requests dropped
// MEM_RUN  | array accepts reads and writes
module memory_sync_dp
  import memory_pkg::*;
#(
  parameter int       N  = 32,
  parameter int       D  = 1024,
  parameter int       A  = $clog2(D),
  parameter int       L  = 1,
  parameter bit       WM = MEM_READ_FIRST,
  parameter bit       RV = 1'b0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           wren,
  input  logic [A-1:0]   waddr,
  input  logic [N/8-1:0] wstrb,
  input  logic [N-1:0]   wdata,
  input  logic           rden,
  input  logic [A-1:0]   raddr,
  output logic           ready,
  output logic           rvalid,
  output logic [N-1:0]   rdata
);

  localparam int NB = N / 8;

  mem_state_e     state_q, state_d;
  logic           ready_q, ready_d;
  logic           we;
  logic [A-1:0]   wa;
  logic [NB-1:0]  ws;
  logic [N-1:0]   wd;
  logic           rd_fire;
  logic [N-1:0]   rd_word;
  logic [N-1:0]   mem_q [D];

`ifdef MEMORY_INIT_EN
  localparam mem_state_e   RST_STATE = MEM_INIT;
  localparam logic [A-1:0] LAST_ADDR = A'(D - 1);

  logic [A-1:0] init_addr_q, init_addr_d;
`else
  localparam mem_state_e RST_STATE = MEM_RUN;

  logic unused_rv;
  assign unused_rv = RV;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RST_STATE;
      ready_q <= 1'b0;
`ifdef MEMORY_INIT_EN
      init_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
`ifdef MEMORY_INIT_EN
      init_addr_q <= init_addr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef MEMORY_INIT_EN
    init_addr_d = init_addr_q;
`endif
    case (state_q)
`ifdef MEMORY_INIT_EN
      MEM_INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d = MEM_RUN;
        end
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // ready is registered so it stays low during reset even when the reset state is RUN
  always_comb begin
    ready_d = (state_d == MEM_RUN);
    we      = ready_q & wren;
    wa      = waddr;
    ws      = wstrb;
    wd      = wdata;
    rd_fire = ready_q & rden;
`ifdef MEMORY_INIT_EN
    if (state_q == MEM_INIT) begin
      we = 1'b1;
      wa = init_addr_q;
      ws = '1;
      wd = {N{RV}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NB; k++) begin
        if (ws[k]) begin
          mem_q[wa][8*k +: 8] <= wd[8*k +: 8];
        end
      end
    end
  end

  // The array read sees pre-write contents; write-first patches in the strobed lanes.
  always_comb begin
    rd_word = mem_q[raddr];
    if (WM == MEM_WRITE_FIRST && we && wa == raddr) begin
      for (int k = 0; k < NB; k++) begin
        if (ws[k]) begin
          rd_word[8*k +: 8] = wd[8*k +: 8];
        end
      end
    end
  end

  memory_rd_pipe #(
    .N (N),
    .L (L)
  ) u_rd_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld   (rd_fire),
    .in_data  (rd_word),
    .out_vld  (rvalid),
    .out_data (rdata)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_memory_sync_dp.sv
// Directed bench: two instances share stimulus, one L=1 read-first, one L=2 write-first.
module tb_memory_sync_dp;
  import memory_pkg::*;

`ifdef MEMORY_INIT_EN
  localparam int EXP_RDY = 16;
`else
  localparam int EXP_RDY = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        wren;
  logic [3:0]  waddr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        rden;
  logic [3:0]  raddr;

  logic        ready1, rvalid1, ready2, rvalid2;
  logic [31:0] rdata1, rdata2;

  logic [31:0] model [16];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  memory_sync_dp #(.N(32), .D(16), .L(1), .WM(MEM_READ_FIRST), .RV(1'b1)) u_l1 (
    .clk(clk), .rstn(rstn), .wren(wren), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
    .rden(rden), .raddr(raddr), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1)
  );

  memory_sync_dp #(.N(32), .D(16), .L(2), .WM(MEM_WRITE_FIRST), .RV(1'b1)) u_l2 (
    .clk(clk), .rstn(rstn), .wren(wren), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
    .rden(rden), .raddr(raddr), .ready(ready2), .rvalid(rvalid2), .rdata(rdata2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 1; i <= EXP_RDY; i++) begin
`ifdef MEMORY_INIT_EN
      if (i == 4) begin
        wren = 1'b1; waddr = 4'd9; wstrb = 4'hF; wdata = 32'h0;
        rden = 1'b1; raddr = 4'd9;
      end
`endif
      tick();
      wren = 1'b0;
      rden = 1'b0;
      check("ready1_rise", ready1, i == EXP_RDY);
      check("ready2_rise", ready2, i == EXP_RDY);
      check("init_rvalid1", rvalid1, 1'b0);
      check("init_rvalid2", rvalid2, 1'b0);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
    wren = 1'b1; waddr = a; wstrb = s; wdata = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic burst(input int n);
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        rden = 1'b1; raddr = 4'(c);
      end else begin
        rden = 1'b0;
      end
      tick();
      check("burst_l1_vld", rvalid1, c < n);
      if (c < n) check("burst_l1_dat", rdata1, model[c]);
      check("burst_l2_vld", rvalid2, c >= 1);
      if (c >= 1) check("burst_l2_dat", rdata2, model[c-1]);
    end
    tick();
    check("burst_l2_end", rvalid2, 1'b0);
    check("hold_l1_dat", rdata1, model[n-1]);
    check("hold_l2_dat", rdata2, model[n-1]);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] ra, input logic [31:0] e1,
                          input logic [31:0] e2, input logic dw, input logic [3:0] ws,
                          input logic [31:0] wd);
    rden = 1'b1; raddr = ra;
    wren = dw; waddr = ra; wstrb = ws; wdata = wd;
    tick();
    rden = 1'b0; wren = 1'b0;
    check({tag, "_l1_vld"}, rvalid1, 1'b1);
    check({tag, "_l1_dat"}, rdata1, e1);
    check({tag, "_l2_early"}, rvalid2, 1'b0);
    tick();
    check({tag, "_l1_pulse"}, rvalid1, 1'b0);
    check({tag, "_l2_vld"}, rvalid2, 1'b1);
    check({tag, "_l2_dat"}, rdata2, e2);
  endtask

  initial begin
    rstn = 1'b0; wren = 1'b0; waddr = '0; wstrb = '0; wdata = '0; rden = 1'b0; raddr = '0;
    tick();
    tick();
    check("rst_ready1", ready1, 1'b0);
    check("rst_ready2", ready2, 1'b0);
    check("rst_rvalid1", rvalid1, 1'b0);
    check("rst_rvalid2", rvalid2, 1'b0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);

    rstn = 1'b1;
    wait_ready();

`ifdef MEMORY_INIT_EN
    for (int i = 0; i < 16; i++) model[i] = 32'hFFFF_FFFF;
`else
    for (int i = 0; i < 16; i++) begin
      model[i] = 32'hA5A5_0000 | i;
      wr(4'(i), 4'hF, model[i]);
    end
`endif
    burst(16);

    for (int i = 0; i < 8; i++) begin
      model[i] = 32'h0101_0101 * i;
      wr(4'(i), 4'hF, model[i]);
    end
    burst(8);

    wr(4'd3, 4'hF, 32'h1122_3344);
    wr(4'd3, 4'b0101, 32'hAABB_CCDD);
    read_chk("strobe", 4'd3, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0, 4'h0, 32'h0);
    wr(4'd3, 4'h0, 32'hFFFF_FFFF);
    read_chk("nostrb", 4'd3, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0, 4'h0, 32'h0);

    wr(4'd5, 4'hF, 32'h0);
    read_chk("coll_full", 4'd5, 32'h0, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'hDEAD_BEEF);
    read_chk("after_coll", 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0);
    read_chk("coll_part", 4'd5, 32'hDEAD_BEEF, 32'hDEAD_5678, 1'b1, 4'b0011, 32'h1234_5678);
    read_chk("after_part", 4'd5, 32'hDEAD_5678, 32'hDEAD_5678, 1'b0, 4'h0, 32'h0);

    rden = 1'b1; raddr = 4'd2;
    tick();
    rden = 1'b0;
    check("mid_l1_vld", rvalid1, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_vld1", rvalid1, 1'b0);
    check("mid_rst_vld2", rvalid2, 1'b0);
    check("mid_rst_rdy1", ready1, 1'b0);
    check("mid_rst_rdy2", ready2, 1'b0);
    check("mid_rst_dat1", rdata1, 32'h0);
    tick();
    tick();
    check("mid_rst_late2", rvalid2, 1'b0);
    rstn = 1'b1;
    wait_ready();
`ifdef MEMORY_INIT_EN
    read_chk("resweep", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
